// File: rtl/bcd_a_bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// Each SHIFT cycle moves one bit out of the BCD register into the binary
// register (LSB first), then subtracts 3 from every digit that is now >= 8.
// After BIN_W shifts the binary register holds the converted value.
module bcd_a_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BCD_W-1:0]   bcd_nxt;
    logic [BIN_W-1:0]   bin_reg;
    logic [BIN_W-1:0]   bin_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               bad_in;
    logic               last_shift;

    // True when any nibble of the word is not a decimal digit (A..F).
    function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[4*d +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Undo the add-3 of the forward algorithm: a digit that received a
    // carried-in 8 from the digit above must lose 3 to stay a valid half.
    function automatic logic [BCD_W-1:0] fix_digits(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[4*d+3]) r[4*d +: 4] = v[4*d +: 4] - 4'd3;
        end
        return r;
    endfunction

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign accept     = in_valid && in_ready;
    assign bad_in     = has_bad_digit(bcd_in);
    assign last_shift = (cnt == CNT_LAST);
    assign bin_nxt    = {bcd_reg[0], bin_reg[BIN_W-1:1]};
    assign bcd_nxt    = fix_digits(bcd_reg >> 1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: IDLE -> SHIFT (or straight to DONE on a bad digit),
    // SHIFT for BIN_W cycles, DONE until the consumer takes the result.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = bad_in ? DONE : SHIFT;
            end
            SHIFT: begin
                if (last_shift) state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Conversion datapath and result registers; bin_out/err only change on
    // acceptance or the final shift, so they stay stable throughout DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_reg <= '0;
            bin_reg <= '0;
            cnt     <= '0;
            bin_out <= '0;
            err     <= 1'b0;
        end else if (accept) begin
            if (bad_in) begin
                bin_out <= '0;
                err     <= 1'b1;
            end else begin
                bcd_reg <= bcd_in;
                bin_reg <= '0;
                cnt     <= '0;
                err     <= 1'b0;
            end
        end else if (state == SHIFT) begin
            bin_reg <= bin_nxt;
            bcd_reg <= bcd_nxt;
            cnt     <= cnt + 1'b1;
            if (last_shift) bin_out <= bin_nxt;
        end
    end

endmodule
